// File: rtl/m68k_bus_target.sv
// 68000 bus target: decodes a fixed address window on an asynchronous 68000 bus
// and serves it from word-wide RAM with programmable DTACK wait and a BERR watchdog.
module m68k_bus_target #(
  parameter logic [23:0] BASE_ADDR    = 24'h200000,
  parameter int          ADDR_BITS    = 10,
  parameter int          WAIT_STATES  = 4,
  parameter int          BERR_TIMEOUT = 4096
) (
  input  logic        PI_CLK,
  input  logic        RESET,
  input  logic        M68K_AS_n,
  input  logic        M68K_UDS_n,
  input  logic        M68K_LDS_n,
  input  logic        M68K_RW,
  input  logic [2:0]  M68K_FC,
  input  logic [23:1] M68K_A,
  input  logic [15:0] M68K_D_IN,
  input  logic        M68K_DTACK_IN_n,
  input  logic        M68K_VPA_n,
  output logic [15:0] M68K_D_OUT,
  output logic        M68K_D_OE,
  output logic        M68K_DTACK_n,
  output logic        M68K_BERR_n,
  output logic        HIT,
  output logic [2:0]  dbg_state_o
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_DECODE  = 3'd1,
    S_WAIT    = 3'd2,
    S_ACK     = 3'd3,
    S_RELEASE = 3'd4
  } state_t;

  localparam logic [7:0] WS    = 8'(WAIT_STATES);
  localparam int         WD_W  = (BERR_TIMEOUT > 0) ? $clog2(BERR_TIMEOUT + 1) : 1;
  localparam logic [WD_W-1:0] WD_MAX = WD_W'(BERR_TIMEOUT);
  localparam bit         WD_EN = (BERR_TIMEOUT > 0);

  // Sync bits: [0]=AS [1]=UDS [2]=LDS [3]=RW [4]=DTACK_IN [5]=VPA.
  // Strobes reset as asserted so a cycle in flight at reset must end before a hit.
  localparam logic [5:0] SYNC_RST = 6'b111000;

  logic [5:0] sync1_q, sync2_q;
  logic       as_s, uds_s, lds_s, rw_s, dtin_s, vpa_s;

  state_t                 state_q;
  logic [ADDR_BITS-1:0]   idx_q;
  logic                   rw_q, uds_q, lds_q, armed_q;
  logic [7:0]             wait_q;
  logic [15:0]            dout_q;
  logic                   oe_q, dtack_q, hit_q, berr_q;
  logic [WD_W-1:0]        wd_cnt_q, wd_cnt_d;
  logic [15:0]            ram_q [0:(1<<ADDR_BITS)-1];

  logic hit, enter_ack, wd_run, bus_idle;

  always_ff @(posedge PI_CLK or posedge RESET) begin
    if (RESET) begin
      sync1_q <= SYNC_RST;
      sync2_q <= SYNC_RST;
    end else begin
      sync1_q <= {M68K_VPA_n, M68K_DTACK_IN_n, M68K_RW, M68K_LDS_n, M68K_UDS_n, M68K_AS_n};
      sync2_q <= sync1_q;
    end
  end

  assign as_s   = sync2_q[0];
  assign uds_s  = sync2_q[1];
  assign lds_s  = sync2_q[2];
  assign rw_s   = sync2_q[3];
  assign dtin_s = sync2_q[4];
  assign vpa_s  = sync2_q[5];

  assign bus_idle  = as_s && uds_s && lds_s;
  assign hit       = (state_q == S_IDLE) && armed_q && !as_s && (!uds_s || !lds_s) &&
                     (M68K_FC != 3'b111) &&
                     (M68K_A[23:ADDR_BITS+1] == BASE_ADDR[23:ADDR_BITS+1]);
  assign enter_ack = ((state_q == S_DECODE) && (WS == 8'd0)) ||
                     ((state_q == S_WAIT) && (wait_q == 8'd1));

  always_ff @(posedge PI_CLK or posedge RESET) begin
    if (RESET) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      rw_q    <= 1'b1;
      uds_q   <= 1'b1;
      lds_q   <= 1'b1;
      wait_q  <= '0;
      armed_q <= 1'b0;
      dout_q  <= '0;
      oe_q    <= 1'b0;
      dtack_q <= 1'b1;
      hit_q   <= 1'b0;
    end else begin
      hit_q <= 1'b0;
      if (bus_idle) armed_q <= 1'b1;
      case (state_q)
        S_IDLE: if (hit) begin
          idx_q   <= M68K_A[ADDR_BITS:1];
          rw_q    <= rw_s;
          uds_q   <= uds_s;
          lds_q   <= lds_s;
          hit_q   <= 1'b1;
          state_q <= S_DECODE;
        end
        S_DECODE: begin
          dout_q  <= ram_q[idx_q];
          wait_q  <= WS;
          state_q <= S_WAIT;
        end
        S_WAIT:    wait_q <= wait_q - 8'd1;
        S_ACK: if (as_s) begin
          state_q <= S_RELEASE;
          dtack_q <= 1'b1;
          oe_q    <= 1'b0;
        end
        S_RELEASE: if (bus_idle) state_q <= S_IDLE;
        default:   state_q <= S_IDLE;
      endcase
      if (enter_ack) begin
        state_q <= S_ACK;
        dtack_q <= 1'b0;
        oe_q    <= rw_q;
      end
    end
  end

  // Exactly one write per access: only on the transition into ACK.
  always_ff @(posedge PI_CLK) begin
    if (enter_ack && !rw_q) begin
      if (!uds_q) ram_q[idx_q][15:8] <= M68K_D_IN[15:8];
      if (!lds_q) ram_q[idx_q][7:0]  <= M68K_D_IN[7:0];
    end
  end

  assign wd_run = WD_EN && (state_q == S_IDLE) && !as_s && !hit && dtin_s && vpa_s;

  always_comb begin
    wd_cnt_d = wd_cnt_q;
    if (as_s) wd_cnt_d = '0;
    else if (wd_run && (wd_cnt_q != WD_MAX)) wd_cnt_d = wd_cnt_q + WD_W'(1);
  end

  always_ff @(posedge PI_CLK or posedge RESET) begin
    if (RESET) begin
      wd_cnt_q <= '0;
      berr_q   <= 1'b1;
    end else begin
      wd_cnt_q <= wd_cnt_d;
      if (as_s) berr_q <= 1'b1;
      else if (WD_EN && (wd_cnt_d == WD_MAX)) berr_q <= 1'b0;
    end
  end

  assign M68K_D_OUT   = dout_q;
  assign M68K_D_OE    = oe_q;
  assign M68K_DTACK_n = dtack_q;
  assign M68K_BERR_n  = berr_q;
  assign HIT          = hit_q;
  assign dbg_state_o  = state_q;

endmodule
